// File: rtl/cond_sum_pkg.sv
// rtl/cond_sum_pkg.sv - shared widths and stage payload types for cond_sum_pipe
package cond_sum_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 16;

  // Stage 1 holds the already-selected operand pair plus which pair won.
  typedef struct packed {
    logic [WIDTH_DEF-1:0] p1;
    logic [WIDTH_DEF-1:0] p2;
    logic                 sel_b;
  } s1_payload_t;

  // Stage 2 holds the finished sum as presented downstream.
  typedef struct packed {
    logic [WIDTH_DEF-1:0] result;
    logic                 carry;
    logic                 sel_b;
  } s2_payload_t;

endpackage

// File: rtl/pair_add.sv
// rtl/pair_add.sv - W-bit adder with carry-out, purely combinational
module pair_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  // Widen by one bit so the carry falls out of the same add.
  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/cond_sum_pipe.sv
// rtl/cond_sum_pipe.sv - two-stage back-pressured select-and-add pipeline
module cond_sum_pipe
  import cond_sum_pkg::*;
#(
  // Payload structs are sized by WIDTH_DEF, so WIDTH is expected to match it.
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a1,
  input  logic [WIDTH-1:0] in_a2,
  input  logic [WIDTH-1:0] in_b1,
  input  logic [WIDTH-1:0] in_b2,
  input  logic [WIDTH-1:0] in_c1,
  input  logic [WIDTH-1:0] in_c2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_sel_b,
  output logic [CNT_W-1:0] result_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic        s1_valid_q, s1_valid_d;
  logic        s2_valid_q, s2_valid_d;
  s1_payload_t s1_q, s1_d;
  s2_payload_t s2_q, s2_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             s1_adv, s2_adv, accept, out_fire;
  logic [WIDTH-1:0] sel_sum;
  logic             sel_carry_unused;
  logic [WIDTH-1:0] pair_sum;
  logic             pair_carry;

  // Selector sum: only its wrapped value matters, the carry is irrelevant.
  pair_add #(.W(WIDTH)) u_sel_add (
    .a     (in_a1),
    .b     (in_a2),
    .sum   (sel_sum),
    .carry (sel_carry_unused)
  );

  // Sum of the pair chosen in stage 1.
  pair_add #(.W(WIDTH)) u_pair_add (
    .a     (s1_q.p1),
    .b     (s1_q.p2),
    .sum   (pair_sum),
    .carry (pair_carry)
  );

  // A stage may load when it is empty or its contents move on this cycle.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  // Next-state for both stages and the completion counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    count_d    = count_q;

    if (s1_adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_d.sel_b = (sel_sum != '0);
        s1_d.p1    = (sel_sum != '0) ? in_b1 : in_c1;
        s1_d.p2    = (sel_sum != '0) ? in_b2 : in_c2;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d.result = pair_sum;
        s2_d.carry  = pair_carry;
        s2_d.sel_b  = s1_q.sel_b;
      end
    end

    if (out_fire && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Stage registers and counter; reset discards anything in flight.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
      count_q    <= count_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_result   = s2_q.result;
  assign out_carry    = s2_q.carry;
  assign out_sel_b    = s2_q.sel_b;
  assign result_count = count_q;

endmodule

// File: tb/tb_cond_sum_pipe.sv
// tb/tb_cond_sum_pipe.sv - directed self-checking bench for cond_sum_pipe
module tb_cond_sum_pipe;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_a1, in_a2, in_b1, in_b2, in_c1, in_c2;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_result;
  logic          out_carry, out_sel_b;
  logic [CW-1:0] result_count;

  int checks = 0;
  int errors = 0;

  // {sel_b, carry, result} expected for the back-to-back stream
  logic [9:0] exp_b2b [8] = '{10'h001 | 10'h100, 10'h21F, 10'h22F, 10'h23F,
                             10'h24F, 10'h25F, 10'h26F, 10'h27F};
  // {sel_b, carry, result} expected for the stall scenario
  logic [9:0] exp_stall [5] = '{10'h221, 10'h222, 10'h223, 10'h224, 10'h103};

  cond_sum_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a1        (in_a1),
    .in_a2        (in_a2),
    .in_b1        (in_b1),
    .in_b2        (in_b2),
    .in_c1        (in_c1),
    .in_c2        (in_c2),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .out_sel_b    (out_sel_b),
    .result_count (result_count)
  );

  always #5 clock = ~clock;

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a1, input logic [7:0] a2,
                       input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] c1, input logic [7:0] c2);
    in_valid = v;
    in_a1 = a1; in_a2 = a2;
    in_b1 = b1; in_b2 = b2;
    in_c1 = c1; in_c2 = c2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    #2;
    checks++;
    if ({out_valid, out_carry, out_sel_b, out_result, result_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ov=%0b c=%0b s=%0b r=%h cnt=%0d want all 0",
               out_valid, out_carry, out_sel_b, out_result, result_count);
    end
    do_reset();
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result_count !== 4'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got ov=%0b ir=%0b cnt=%0d want 0 1 0",
                 i, out_valid, in_ready, result_count);
      end
      next_cycle();
    end
  endtask

  task automatic test_single(input string name, input logic [7:0] a1, input logic [7:0] a2,
                             input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] c1, input logic [7:0] c2,
                             input logic [9:0] expv);
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, a1, a2, b1, b2, c1, c2);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready: got %0b want 1", name, in_ready);
    end
    next_cycle();
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s early_valid: got %0b want 0", name, out_valid);
    end
    next_cycle();
    #1;
    checks++;
    if (out_valid !== 1'b1 || {out_sel_b, out_carry, out_result} !== expv) begin
      errors++;
      $display("FAIL %s result: got ov=%0b {s,c,r}=%h want ov=1 %h",
               name, out_valid, {out_sel_b, out_carry, out_result}, expv);
    end
    next_cycle();
    #1;
    checks++;
    if (result_count !== 4'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s count: got cnt=%0d ov=%0b want 1 0", name, result_count, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int got, first, last;
    got = 0; first = -1; last = -1;
    do_reset();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 8) drive(1'b1, 8'(cyc), 8'h00, 8'(cyc * 16), 8'h0F, 8'hFF, 8'h02);
      else         drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b in_ready cycle %0d: got %0b want 1", cyc, in_ready);
      end
      if (out_valid === 1'b1) begin
        if (first < 0) first = cyc;
        last = cyc;
        checks++;
        if (got >= 8) begin
          errors++;
          $display("FAIL b2b extra output: got %0d outputs want 8", got + 1);
        end else if ({out_sel_b, out_carry, out_result} !== exp_b2b[got]) begin
          errors++;
          $display("FAIL b2b data %0d: got %h want %h", got,
                   {out_sel_b, out_carry, out_result}, exp_b2b[got]);
        end
        got++;
      end
      next_cycle();
    end
    checks++;
    if (got != 8 || (last - first) != 7) begin
      errors++;
      $display("FAIL b2b count: got %0d outputs span %0d want 8 span 7", got, last - first);
    end
  endtask

  task automatic test_stall();
    int sent, got;
    sent = 0; got = 0;
    do_reset();
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = (cyc >= 5);
      if (sent < 4)       drive(1'b1, 8'h01, 8'h00, 8'(sent + 1), 8'h20, 8'h00, 8'h00);
      else if (sent == 4) drive(1'b1, 8'h00, 8'h00, 8'h55, 8'h55, 8'hFE, 8'h05);
      else                drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      #1;
      if (cyc < 2) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL stall fill in_ready cycle %0d: got %0b want 1", cyc, in_ready);
        end
      end else if (cyc < 5) begin
        checks++;
        if (in_ready !== 1'b0 || sent != 2 || out_valid !== 1'b1 ||
            {out_sel_b, out_carry, out_result} !== exp_stall[0]) begin
          errors++;
          $display("FAIL stall hold cycle %0d: got ir=%0b sent=%0d ov=%0b %h want 0 2 1 %h",
                   cyc, in_ready, sent, out_valid, {out_sel_b, out_carry, out_result},
                   exp_stall[0]);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (got >= 5) begin
          errors++;
          $display("FAIL stall extra output: got %0d outputs want 5", got + 1);
        end else if ({out_sel_b, out_carry, out_result} !== exp_stall[got]) begin
          errors++;
          $display("FAIL stall data %0d: got %h want %h", got,
                   {out_sel_b, out_carry, out_result}, exp_stall[got]);
        end
        got++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) sent++;
      next_cycle();
    end
    checks++;
    if (sent != 5 || got != 5 || result_count !== 4'd5) begin
      errors++;
      $display("FAIL stall totals: got sent=%0d out=%0d cnt=%0d want 5 5 5",
               sent, got, result_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 8'h01, 8'h01, 8'h10, 8'h20, 8'h00, 8'h00);
    next_cycle();
    drive(1'b1, 8'h02, 8'h01, 8'h30, 8'h40, 8'h00, 8'h00);
    next_cycle();
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 8'h30) begin
      errors++;
      $display("FAIL midreset inflight: got ov=%0b r=%h want 1 30", out_valid, out_result);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result_count !== 4'd0 || out_result !== 8'h00) begin
      errors++;
      $display("FAIL midreset async: got ov=%0b cnt=%0d r=%h want 0 0 00",
               out_valid, result_count, out_result);
    end
    #1;
    rst_n = 1'b1;
    next_cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || result_count !== 4'd0) begin
        errors++;
        $display("FAIL midreset ghost cycle %0d: got ov=%0b cnt=%0d want 0 0",
                 i, out_valid, result_count);
      end
      next_cycle();
    end
  endtask

  task automatic test_saturate();
    int hs;
    hs = 0;
    do_reset();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc < 15) drive(1'b1, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00);
      else          drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      #1;
      if (out_valid === 1'b1) hs++;
      next_cycle();
    end
    #1;
    checks++;
    if (result_count !== 4'd15 || hs != 15) begin
      errors++;
      $display("FAIL sat reach: got cnt=%0d hs=%0d want 15 15", result_count, hs);
    end
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc < 3) drive(1'b1, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00);
      else         drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      #1;
      if (out_valid === 1'b1) hs++;
      next_cycle();
    end
    #1;
    checks++;
    if (result_count !== 4'd15 || hs != 18) begin
      errors++;
      $display("FAIL sat hold: got cnt=%0d hs=%0d want 15 18", result_count, hs);
    end
  endtask

  initial begin
    test_reset();
    test_single("basic", 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 10'h207);
    test_single("wrap_sel", 8'h80, 8'h80, 8'h01, 8'h01, 8'hF0, 8'h20, 10'h110);
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
